mem_stage: RTL

- Memory-access stage of the 5-stage pipeline, between the EX/MEM boundary and the write-back stage.
- Issues loads and stores to a multi-cycle data memory over a req/ack handshake, and stalls upstream while an access is outstanding.
- Registers the MEM/WB pipeline values ALUOut, MemoryOut and ControlsOut, which the write-back stage consumes directly.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/mem_wb_reg.sv | 28 ++
 rtl/mem_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word bit positions, MEM-stage state
// encoding and the MEM/WB payload layout.
package pipeline_pkg;

    localparam int CTRL_MEMREAD  = 22;
    localparam int CTRL_MEMWRITE = 21;
    localparam int CTRL_MEMTOREG = 20;
    localparam int CTRL_REGWRITE = 19;

    localparam logic [31:0] DEAD_WORD_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] ctrl;
    } mem_wb_t;

    // A failed access must not reach the register file.
    function automatic logic [31:0] clear_regwrite(input logic [31:0] ctrl);
        logic [31:0] c;
        c = ctrl;
        c[CTRL_REGWRITE] = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// Pipeline boundary register: data loads on enable; valid is a one-cycle
// pulse marking the cycle in which new data was captured.
module mem_wb_reg #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack handshake,
// stalls upstream while waiting, and produces the MEM/WB register values.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] DEAD_WORD = DEAD_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exValid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] storeData,
    input  logic [31:0] Controls,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic [31:0] ALUOut,
    output logic [31:0] MemoryOut,
    output logic [31:0] ControlsOut,
    output logic        wbValid,
    output logic        memError
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mem_state_e  state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic        is_load_q, is_load_d;
    logic        req_d, we_d, err_d;
    logic [31:0] addr_d, wdata_d;

    logic        is_mem_op;
    logic        wb_load;
    mem_wb_t     wb_d, wb_q;

    assign is_mem_op = Controls[CTRL_MEMREAD] | Controls[CTRL_MEMWRITE];
    assign stall     = (state == WAIT);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ctrl_d    = ctrl_q;
        is_load_d = is_load_q;
        req_d     = memReq;
        we_d      = memWe;
        addr_d    = memAddr;
        wdata_d   = memWData;
        err_d     = memError;
        wb_load   = 1'b0;
        wb_d      = '{alu: ALUResult, mem: 32'h0, ctrl: Controls};

        case (state)
            IDLE: begin
                if (exValid) begin
                    if (!is_mem_op) begin
                        wb_load = 1'b1;
                    end else if (ALUResult[1:0] != 2'b00) begin
                        wb_load     = 1'b1;
                        wb_d.ctrl   = clear_regwrite(Controls);
                        err_d       = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        cnt_d     = 8'd0;
                        ctrl_d    = Controls;
                        // Read wins when both memRead and memWrite are set.
                        is_load_d = Controls[CTRL_MEMREAD];
                        req_d     = 1'b1;
                        we_d      = Controls[CTRL_MEMWRITE] & ~Controls[CTRL_MEMREAD];
                        addr_d    = ALUResult;
                        wdata_d   = storeData;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt + 8'd1;
                // memAddr is the latched ALUResult of the outstanding access.
                wb_d.alu = memAddr;
                if (memAck) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    wb_load   = 1'b1;
                    wb_d.mem  = is_load_q ? memRData : 32'h0;
                    wb_d.ctrl = ctrl_q;
                end else if (cnt == CNT_LAST) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    wb_load   = 1'b1;
                    wb_d.mem  = DEAD_WORD;
                    wb_d.ctrl = clear_regwrite(ctrl_q);
                    err_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ctrl_q    <= 32'h0;
            is_load_q <= 1'b0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= 32'h0;
            memWData  <= 32'h0;
            memError  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ctrl_q    <= ctrl_d;
            is_load_q <= is_load_d;
            memReq    <= req_d;
            memWe     <= we_d;
            memAddr   <= addr_d;
            memWData  <= wdata_d;
            memError  <= err_d;
        end
    end

    mem_wb_reg #(.W($bits(mem_wb_t))) u_mem_wb (
        .clk   (clk),
        .reset (reset),
        .load  (wb_load),
        .d     (wb_d),
        .q     (wb_q),
        .valid (wbValid)
    );

    assign ALUOut      = wb_q.alu;
    assign MemoryOut   = wb_q.mem;
    assign ControlsOut = wb_q.ctrl;

endmodule
